// File: rtl/regfile_multiport_pkg.sv
// regfile_multiport_pkg
//   Shared definitions for the multiport register file:
//   - clr_state_e : clear-engine states (IDLE, CLEAR)
//   - DEF_DATA_W / DEF_ADDR_W : default word and index widths
//   - depth_of()  : number of entries addressed by an index of a given width
package regfile_multiport_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_decoder.sv
// regfile_decoder
//   Parametrised ADDR_W-to-2^ADDR_W one-hot decoder with enable.
//   Ports:
//     i_en   : enable; when low every wordline is low
//     i_addr : index to decode
//     o_wl   : one-hot wordline, bit i_addr set when enabled
module regfile_decoder
  import regfile_multiport_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                          i_en,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic [depth_of(ADDR_W)-1:0]   o_wl
);

  always_comb begin
    o_wl = '0;
    if (i_en) begin
      o_wl[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport
//   2^ADDR_W x DATA_W register file with one write port, NUM_RD registered
//   read ports, same-cycle write-to-read bypass, optional hardwired zero
//   entry and a sequential clear engine (one entry zeroed per cycle).
//   Ports:
//     clk, rst  : clock (rising edge), synchronous active-high reset
//     wr_en/wr_addr/wr_data : write request
//     rd_en     : per-port read request (NUM_RD bits)
//     rd_addr   : packed read indices, port p at [p*ADDR_W +: ADDR_W]
//     rd_data   : packed registered read data, port p at [p*DATA_W +: DATA_W]
//     clr_req   : request to zero every entry
//     busy      : clear in progress
//     wr_drop   : write presented while busy and therefore discarded
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       wr_drop
);

  localparam int                DEPTH    = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DEPTH-1:0]  w_wr_wl;
  logic [DEPTH-1:0]  w_clr_wl;
  logic              w_busy;
  logic              w_wr_zero;
  logic              w_wr_ok;

  assign w_busy    = (r_state == CLEAR);
  // With a hardwired zero entry, writes to index 0 are silently absorbed:
  // they neither update storage nor bypass, and they are not counted as drops.
  assign w_wr_zero = (ZERO_REG != 0) && (wr_addr == ZERO_IDX);
  assign w_wr_ok   = wr_en && !w_busy && !w_wr_zero;

  assign busy    = w_busy;
  assign wr_drop = wr_en && w_busy;

  regfile_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wr_dec (
    .i_en   (w_wr_ok),
    .i_addr (wr_addr),
    .o_wl   (w_wr_wl)
  );

  // The clear engine reuses the decoder to select the entry being zeroed.
  regfile_decoder #(
    .ADDR_W (ADDR_W)
  ) u_clr_dec (
    .i_en   (w_busy),
    .i_addr (r_cnt),
    .o_wl   (w_clr_wl)
  );

  // ---- clear engine: next state ----
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        // Counter wraps to 0 naturally on the terminal increment.
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---- clear engine: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---- storage ----
  // Clear and write wordlines never overlap: writes are only accepted
  // while the clear engine is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_clr_wl[i]) begin
          r_mem[i] <= '0;
        end else if (w_wr_wl[i]) begin
          r_mem[i] <= wr_data;
        end
      end
    end
  end

  // ---- read ports ----
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] r_data;

    assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Priority: clear forces 0, then bypass of the accepted write, then the
    // zero entry, then storage. w_wr_ok already excludes index 0 when the
    // zero entry is enabled, so bypass never reaches it.
    always_comb begin
      w_rdata = r_mem[w_addr];
      if (w_busy) begin
        w_rdata = '0;
      end else if (w_wr_ok && (wr_addr == w_addr)) begin
        w_rdata = wr_data;
      end else if ((ZERO_REG != 0) && (w_addr == ZERO_IDX)) begin
        w_rdata = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data <= '0;
      end else if (rd_en[p]) begin
        r_data <= w_rdata;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = r_data;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  rd_en;
  logic [4:0]  ra [3];
  logic        clr_req;

  logic [31:0] a_rd_data;
  logic        a_busy;
  logic        a_wr_drop;
  logic [95:0] b_rd_data;
  logic        b_busy;
  logic        b_wr_drop;

  int    n_chk;
  int    n_fail;
  string phase;

  // Reference model state, index 0 = default build, 1 = wide build.
  logic [31:0] m_mem  [2][32];
  logic [31:0] m_rd   [2][3];
  int          m_left [2];
  int          m_idx  [2];

  regfile_multiport u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr[3:0]),
    .wr_data (wr_data[15:0]),
    .rd_en   (rd_en[1:0]),
    .rd_addr ({ra[1][3:0], ra[0][3:0]}),
    .rd_data (a_rd_data),
    .clr_req (clr_req),
    .busy    (a_busy),
    .wr_drop (a_wr_drop)
  );

  regfile_multiport #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (3),
    .ZERO_REG (0)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr ({ra[2], ra[1], ra[0]}),
    .rd_data (b_rd_data),
    .clr_req (clr_req),
    .busy    (b_busy),
    .wr_drop (b_wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_rd(input int d, input int p);
    if (d == 0) return {16'h0000, a_rd_data[p*16 +: 16]};
    return b_rd_data[p*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) m_mem[d][i] = '0;
      for (int p = 0; p < 3; p++) m_rd[d][p] = '0;
      m_left[d] = 0;
      m_idx[d]  = 0;
    end
  endtask

  // Applies the storage rules for one clock edge, using the inputs as
  // currently driven.
  task automatic model_step(input int d);
    int          depth;
    int          nr;
    bit          zr;
    logic [31:0] dmask;
    bit          bsy;
    int          wa;
    int          a;
    logic [31:0] wd;
    bit          wok;
    depth = (d == 0) ? 16 : 32;
    nr    = (d == 0) ? 2 : 3;
    zr    = (d == 0);
    dmask = (d == 0) ? 32'h0000FFFF : 32'hFFFFFFFF;
    bsy   = (m_left[d] > 0);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[d][i] = '0;
      for (int p = 0; p < 3; p++) m_rd[d][p] = '0;
      m_left[d] = 0;
      m_idx[d]  = 0;
    end else begin
      wa  = int'(wr_addr) % depth;
      wd  = wr_data & dmask;
      wok = wr_en && !bsy && !(zr && wa == 0);
      for (int p = 0; p < nr; p++) begin
        if (rd_en[p]) begin
          a = int'(ra[p]) % depth;
          if (bsy)                  m_rd[d][p] = '0;
          else if (wok && a == wa)  m_rd[d][p] = wd;
          else if (zr && a == 0)    m_rd[d][p] = '0;
          else                      m_rd[d][p] = m_mem[d][a];
        end
      end
      if (bsy) begin
        m_mem[d][m_idx[d]] = '0;
        m_idx[d]++;
        m_left[d]--;
      end else begin
        if (wok) m_mem[d][wa] = wd;
        if (clr_req) begin
          m_left[d] = depth;
          m_idx[d]  = 0;
        end
      end
    end
  endtask

  // One clock cycle: check status outputs before the edge, advance the
  // model, then check every read port after the edge.
  task automatic cyc();
    logic bz;
    logic dr;
    #1;
    for (int d = 0; d < 2; d++) begin
      bz = (d == 0) ? a_busy : b_busy;
      dr = (d == 0) ? a_wr_drop : b_wr_drop;
      chk($sformatf("%s.busy%0d", phase, d), {31'd0, bz}, {31'd0, m_left[d] > 0});
      chk($sformatf("%s.drop%0d", phase, d), {31'd0, dr}, {31'd0, wr_en && (m_left[d] > 0)});
    end
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < ((d == 0) ? 2 : 3); p++) begin
        chk($sformatf("%s.rd%0d.p%0d", phase, d, p), get_rd(d, p), m_rd[d][p]);
      end
    end
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    clr_req = 1'b0;
    for (int i = 0; i < 3; i++) ra[i] = '0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 80; k++) begin
      if (!a_busy && !b_busy) break;
      cyc();
    end
    chk("wait_idle", {30'd0, a_busy, b_busy}, 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int drop_cnt;
    int drop_at;
    n_chk  = 0;
    n_fail = 0;
    phase  = "reset";
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    cyc();
    rst = 1'b0;

    // Reset then read
    rd_en = 3'b011; ra[0] = 5'd3; ra[1] = 5'd15;
    cyc();
    chk("rst_rd_p0", get_rd(0, 0), 32'h0000);
    chk("rst_rd_p1", get_rd(0, 1), 32'h0000);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);

    // Write then read next cycle
    phase = "wrrd";
    rd_en = '0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000BEEF;
    cyc();
    wr_en = 1'b0; rd_en = 3'b010; ra[1] = 5'd5;
    cyc();
    chk("wrrd_p1", get_rd(0, 1), 32'hBEEF);
    chk("wrrd_p0_hold", get_rd(0, 0), 32'h0000);

    // Bypass
    phase = "byp";
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00001234; rd_en = 3'b001; ra[0] = 5'd7;
    cyc();
    chk("byp_p0", get_rd(0, 0), 32'h1234);

    // Zero register
    phase = "zero";
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000FFFF; rd_en = '0;
    #1;
    chk("zero_drop", {31'd0, a_wr_drop}, 32'd0);
    cyc();
    wr_en = 1'b0; rd_en = 3'b001; ra[0] = 5'd0;
    cyc();
    chk("zero_rd", get_rd(0, 0), 32'h0000);

    // Clear sequence
    phase = "clr";
    rd_en = '0;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hA5A5A5A5;
      cyc();
    end
    wr_en = 1'b0; clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    busy_cnt = 0; drop_cnt = 0; drop_at = 0;
    for (int k = 0; k < 40; k++) begin
      if (!a_busy) break;
      wr_en = (busy_cnt == 2); wr_addr = 5'd2; wr_data = 32'h00001111;
      #1;
      if (a_wr_drop) begin
        drop_cnt++;
        drop_at = busy_cnt + 1;
      end
      busy_cnt++;
      cyc();
    end
    wr_en = 1'b0;
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("clr_drop_count", 32'(drop_cnt), 32'd1);
    chk("clr_drop_cycle", 32'(drop_at), 32'd3);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      rd_en = 3'b011; ra[0] = 5'(i); ra[1] = 5'(15 - i);
      cyc();
      chk($sformatf("clr_rd_a%0d", i), get_rd(0, 0), 32'h0000);
    end

    // Reset in the middle of a clear
    phase = "rstclr";
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00005555;
    cyc();
    wr_addr = 5'd4;
    cyc();
    wr_en = 1'b0; clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstclr_busy_a", {31'd0, a_busy}, 32'd0);
    chk("rstclr_busy_b", {31'd0, b_busy}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd_en = 3'b111; ra[0] = 5'(i); ra[1] = 5'(i); ra[2] = 5'(i);
      cyc();
      chk($sformatf("rstclr_rd%0d", i), get_rd(1, 0) | get_rd(0, 0), 32'h0);
    end
    rd_en = '0; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00009999;
    cyc();
    wr_en = 1'b0; rd_en = 3'b001; ra[0] = 5'd9;
    cyc();
    chk("rstclr_w9_a", get_rd(0, 0), 32'h9999);
    chk("rstclr_w9_b", get_rd(1, 0), 32'h9999);

    // Wide build
    phase = "wide";
    rd_en = '0; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hDEADBEEF;
    cyc();
    wr_en = 1'b0; rd_en = 3'b111; ra[0] = 5'd31; ra[1] = 5'd31; ra[2] = 5'd31;
    cyc();
    for (int p = 0; p < 3; p++) chk($sformatf("wide_w31_p%0d", p), get_rd(1, p), 32'hDEADBEEF);
    rd_en = '0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h600DF00D;
    cyc();
    wr_en = 1'b0; rd_en = 3'b001; ra[0] = 5'd0;
    cyc();
    chk("wide_w0", get_rd(1, 0), 32'h600DF00D);
    rd_en = '0; clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      if (!b_busy) break;
      busy_cnt++;
      cyc();
    end
    chk("wide_busy_cycles", 32'(busy_cnt), 32'd32);
    wait_idle();

    // Randomized traffic against the model
    phase = "rand";
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 149) == 0);
      clr_req = ($urandom_range(0, 49) == 0);
      wr_en   = 1'($urandom);
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      rd_en   = 3'($urandom);
      for (int i = 0; i < 3; i++) ra[i] = 5'($urandom);
      if ($urandom_range(0, 3) == 0) ra[0] = wr_addr;
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised register file that generalises the team's fixed 4-to-16 read-wordline decoder into a complete storage block. It holds 2^ADDR_W words of DATA_W bits, with one write port and NUM_RD registered read ports. It adds write-to-read bypass, an optional hardwired zero register, and a sequential hardware clear engine. It sits in the decode stage of the CPU datapath and replaces the discrete decoder-plus-register arrangement.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 4, register index width; DEPTH = 2^ADDR_W entries
- NUM_RD, 2, number of read ports
- ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are discarded

- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write index
- wr_data  input  DATA_W  write data
- rd_en  input  NUM_RD  per-port read request
- rd_addr  input  NUM_RD*ADDR_W  packed read indices; port p is bits [p*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  packed registered read data; port p is bits [p*DATA_W +: DATA_W]
- clr_req  input  1  single-cycle request to zero every entry
- busy  output  1  clear in progress
- wr_drop  output  1  one-cycle pulse; a write was discarded because busy was high

## Operation
- Writes: wr_addr is decoded to a one-hot DEPTH-bit wordline. When wr_en=1 and busy=0, the selected entry loads wr_data at the clock edge.
- Reads: when rd_en[p]=1, rd_data port p loads the addressed entry at the clock edge. When rd_en[p]=0, port p holds its previous value. Ports are independent, and any ports may address the same entry.
- Bypass: if wr_en=1, busy=0 and wr_addr equals rd_addr port p in the same cycle, port p loads wr_data (write-before-read).
- Zero register: with ZERO_REG=1, entry 0 reads 0 and bypass never applies to index 0. A write to index 0 is a silent no-op; wr_drop stays low.
- Clear state machine, states IDLE and CLEAR:
  - IDLE to CLEAR when clr_req=1. The index counter is set to 0.
  - In CLEAR, the entry at the counter is zeroed each cycle, then the counter increments.
  - CLEAR to IDLE after index DEPTH-1 is zeroed. The counter wraps to 0.
  - clr_req is ignored while in CLEAR.
- During CLEAR:
  - Any wr_en=1 is discarded and wr_drop pulses in that cycle.
  - Reads are accepted, but the loaded rd_data is forced to 0 (deterministic result).
- clr_req and wr_en in the same IDLE cycle: the write completes first, and the clear that follows zeroes it.
- Reset (any cycle, including mid-CLEAR):
  - All entries are 0, all rd_data fields are 0.
  - busy=0, wr_drop=0, state is IDLE, counter is 0.
  - Reset takes priority over every request in that cycle.

## Timing
- Read latency is 1 cycle. Address presented at edge n gives data valid after edge n, stable until the next enabled read on that port.
- Write-to-read:
  - Same cycle: data returned through bypass.
  - Next cycle: data returned from storage.
- Clear:
  - clr_req sampled at edge t sets busy high from after edge t.
  - Entry k is zeroed at edge t+1+k.
  - busy falls after edge t+DEPTH, giving exactly DEPTH busy cycles.
- wr_drop is combinational from wr_en and busy. It is high only in the cycle the dropped request is presented.
- Arithmetic:
  - The counter is ADDR_W bits wide and its terminal value is DEPTH-1.
  - Width-mismatched index comparisons are not permitted. All address comparisons are ADDR_W wide.

## Structure
- Shared package: the state enum (IDLE, CLEAR), the default DATA_W/ADDR_W values, and the DEPTH derivation function.
- Sub-module: regfile_decoder, a parametrised ADDR_W-to-2^ADDR_W one-hot decoder with enable. It supersedes the fixed 4-to-16 decoder.
- One regfile_decoder instance serves as the write wordline. The same module may also drive the clear-engine wordline.
- Read muxing is inline, generated per port.

## Test plan
- Reset then read: assert rst for 2 cycles, then read indices 3 and 15 on ports 0 and 1. Required: both rd_data fields 0x0000 and busy=0.
- Write/read: write 0xBEEF to index 5. Next cycle read index 5 on port 1. Required: port 1 = 0xBEEF one cycle later, while port 0 holds its previous value.
- Bypass and zero register:
  - Write 0x1234 to index 7 while port 0 reads 7 in the same cycle. Required: port 0 = 0x1234.
  - Write 0xFFFF to index 0, then read index 0. Required: 0x0000 and wr_drop=0.
- Clear sequence: fill all 16 entries with 0xA5A5, pulse clr_req, and present a write to index 2 in the 3rd busy cycle. Required:
  - busy is high for exactly 16 cycles.
  - wr_drop pulses once, in the 3rd busy cycle.
  - All entries read 0x0000 afterwards.
- Reset mid-clear: pulse clr_req, then assert rst after 5 busy cycles. Required:
  - busy=0 the cycle after reset.
  - All entries 0x0000.
  - A fresh write to index 9 then reads back correctly.
- Parametric build: DATA_W=32, ADDR_W=5, NUM_RD=3, ZERO_REG=0. Required:
  - Writing 0xDEADBEEF to index 31 reads back on all 3 ports.
  - Writing to index 0 takes effect.
  - A clear lasts 32 busy cycles.
